// File: rtl/fc_pkg.sv
// Shared constants, state encoding and binary32 arithmetic for the FC PE array.
package fc_pkg;

  localparam int          LANE_W  = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    DRAIN = 3'd2,
    BIAS  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // binary32 multiply, round-to-nearest-even, denormal inputs/outputs flushed to zero
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
    logic [47:0]       p;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic signed [9:0] e;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP_QNAN;
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (e <= 10'sd0) return {s, 31'd0};
    return {s, e[7:0], mr[22:0]};
  endfunction

  // binary32 add, round-to-nearest-even, denormal inputs/outputs flushed to zero
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic              a_nan, b_nan, a_inf, b_inf, sub, found;
    logic [7:0]        d;
    logic [49:0]       sh;
    logic [26:0]       xv, yv, n;
    logic [27:0]       r;
    logic [24:0]       mr;
    logic [4:0]        lz;
    logic signed [9:0] e;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (a_nan || b_nan) return FP_QNAN;
    if (a_inf && b_inf && (a[31] != b[31])) return FP_QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if ((a[30:23] == 8'h00) && (b[30:23] == 8'h00)) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    sub = x[31] ^ y[31];
    d   = x[30:23] - y[30:23];
    xv  = {1'b1, x[22:0], 3'b000};
    // smaller operand aligned with guard, round and sticky bits below the mantissa
    if (d >= 8'd50) begin
      sh = 50'd0;
      yv = 27'd1;
    end else begin
      sh = {1'b1, y[22:0], 26'd0} >> d;
      yv = {sh[49:24], |sh[23:0]};
    end
    e  = $signed({2'b00, x[30:23]});
    lz = 5'd0;
    found = 1'b0;
    if (!sub) begin
      r = {1'b0, xv} + {1'b0, yv};
      if (r[27]) begin
        n = {r[27:2], r[1] | r[0]};
        e = e + 10'sd1;
      end else begin
        n = r[26:0];
      end
    end else begin
      r = {1'b0, xv - yv};
      if (r == 28'd0) return FP_ZERO;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (r[i]) found = 1'b1;
          else lz = lz + 5'd1;
        end
      end
      n = r[26:0] << lz;
      e = e - $signed({5'b00000, lz});
    end
    mr = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 10'sd0) return {x[31], 31'd0};
    return {x[31], e[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/fc_lane.sv
// One neuron lane: registered multiply, accumulate, bias add and ReLU output.
module fc_lane
  import fc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              mul_en,
  input  logic              add_prod,
  input  logic              add_bias,
  input  logic              relu_en,
  input  logic [LANE_W-1:0] x,
  input  logic [LANE_W-1:0] w,
  input  logic [LANE_W-1:0] bias,
  output logic [LANE_W-1:0] y
);

  logic [LANE_W-1:0] prod;
  logic [LANE_W-1:0] acc;
  logic [LANE_W-1:0] sum;

  // one shared adder: bias in the BIAS step, the pending product otherwise
  assign sum = fp_add(acc, add_bias ? bias : prod);

  // product register loads on every accepted beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prod <= FP_ZERO;
    else if (mul_en) prod <= fp_mul(x, w);
  end

  // accumulator: cleared at start, then products, then the bias
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc <= FP_ZERO;
    else if (clear) acc <= FP_ZERO;
    else if (add_bias || add_prod) acc <= sum;
  end

  // any set sign bit (including -0.0 and negative NaN) becomes +0.0 under ReLU
  assign y = (relu_en && acc[LANE_W-1]) ? FP_ZERO : acc;

endmodule

// File: rtl/fc_neuron_pe_array.sv
// Fully-connected PE: LANES neurons fed from one broadcast activation stream.
//  state | meaning
//  IDLE  | waiting for start_FC
//  ACC   | accepting input beats, accumulating products
//  DRAIN | last product folds into the accumulators
//  BIAS  | per-lane bias added
//  DONE  | results presented until out_ready
module fc_neuron_pe_array
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int MAX_LEN    = 1024,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start_FC,
  input  logic [LEN_W-1:0]            len,
  input  logic [LANES*DATA_WIDTH-1:0] bias,
  input  logic                        relu_en,
  input  logic [DATA_WIDTH-1:0]       input_fc,
  input  logic [LANES*DATA_WIDTH-1:0] iweight_FC,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*DATA_WIDTH-1:0] output_fc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  state_t                      state, state_nxt;
  logic [LEN_W-1:0]            cnt, len_q;
  logic [LEN_W-1:0]            cnt_nxt;
  logic [LANES*DATA_WIDTH-1:0] bias_q;
  logic                        relu_q;
  logic                        prod_vld;
  logic                        accept, clear, add_bias;

  assign cnt_nxt = cnt + LEN_W'(1);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_FC) state_nxt = (len == '0) ? BIAS : ACC;
      ACC:     if (accept && (cnt_nxt == len_q)) state_nxt = DRAIN;
      DRAIN:   state_nxt = BIAS;
      BIAS:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs and datapath strobes
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    add_bias  = (state == BIAS);
    clear     = (state == IDLE) && start_FC;
    accept    = in_valid && (state == ACC);
  end

  // configuration capture and beat counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      len_q  <= '0;
      bias_q <= '0;
      relu_q <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      len_q  <= len;
      bias_q <= bias;
      relu_q <= relu_en;
    end else if (accept) begin
      cnt <= cnt_nxt;
    end
  end

  // product-valid follows the beat accepted one cycle earlier
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prod_vld <= 1'b0;
    else prod_vld <= accept;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fc_lane u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .mul_en   (accept),
      .add_prod (prod_vld),
      .add_bias (add_bias),
      .relu_en  (relu_q),
      .x        (input_fc),
      .w        (iweight_FC[k*DATA_WIDTH +: DATA_WIDTH]),
      .bias     (bias_q[k*DATA_WIDTH +: DATA_WIDTH]),
      .y        (output_fc[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // only binary32 is supported, and len beyond MAX_LEN is never legal at start
  a_cfg_legal: assert property (@(posedge clk) disable iff (!reset_n)
    (DATA_WIDTH == 32) && (!(start_FC && (state == IDLE)) || (len <= LEN_W'(MAX_LEN))));

endmodule
